// File: rtl/data_bus_responder.sv
// Memory-mapped responder for a CPU data port: word RAM, a byte output FIFO
// with status/overflow reporting, and a free-running loadable cycle counter.
`default_nettype none

module data_bus_responder #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dataAddr,
    input  logic [31:0] dataOut,
    input  logic        dataWrEnable,
    output logic [31:0] dataIn,
    output logic        outValid,
    output logic [7:0]  outData,
    input  logic        outReady
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [15:0]   ADDR_OUT_DATA = 16'hFF00;
    localparam logic [15:0]   ADDR_STATUS   = 16'hFF01;
    localparam logic [15:0]   ADDR_CYCLE    = 16'hFF02;
    localparam logic [CW-1:0] DEPTH_COUNT   = CW'(FIFO_DEPTH);

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifoMem [FIFO_DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   cycleCount;

    logic        ramHit;
    logic        outDataWr;
    logic        statusWr;
    logic        cycleWr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        overflowSet;
    logic [31:0] statusWord;

    assign ramHit    = (32'(dataAddr) < 32'(RAM_WORDS));
    assign outDataWr = dataWrEnable && (dataAddr == ADDR_OUT_DATA);
    assign statusWr  = dataWrEnable && (dataAddr == ADDR_STATUS);
    assign cycleWr   = dataWrEnable && (dataAddr == ADDR_CYCLE);

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_COUNT);
    assign outValid = !empty;
    assign outData  = fifoMem[rdPtr];

    // A pop frees a slot in the same edge, so a full FIFO may still accept a push.
    assign pop         = outValid && outReady;
    assign push        = outDataWr && (!full || pop);
    assign overflowSet = outDataWr && full && !pop;

    assign statusWord = {23'b0, 5'(count), 1'b0, overflow, full, empty};

    always_comb begin
        dataIn = '0;
        if (ramHit) begin
            dataIn = ram[dataAddr[AW-1:0]];
        end else if (dataAddr == ADDR_STATUS) begin
            dataIn = statusWord;
        end else if (dataAddr == ADDR_CYCLE) begin
            dataIn = cycleCount;
        end
    end

    // Storage arrays are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (dataWrEnable && ramHit) begin
            ram[dataAddr[AW-1:0]] <= dataOut;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= dataOut[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Setting wins over a same-cycle clear so an overflow is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (overflowSet) begin
            overflow <= 1'b1;
        end else if (statusWr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycleCount <= '0;
        end else if (cycleWr) begin
            cycleCount <= dataOut;
        end else begin
            cycleCount <= cycleCount + 32'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: a table of single-cycle bus accesses
// plus hand-written sequences for FIFO, counter and reset corner cases.
`timescale 1ns/1ps

module tb_data_bus_responder;

    localparam int FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dataAddr;
    logic [31:0] dataOut;
    logic        dataWrEnable;
    logic [31:0] dataIn;
    logic        outValid;
    logic [7:0]  outData;
    logic        outReady;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        chkData;
        logic [31:0] expData;
    } busVector;

    busVector vecs[15];

    data_bus_responder #(
        .RAM_WORDS(256),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dataAddr(dataAddr),
        .dataOut(dataOut),
        .dataWrEnable(dataWrEnable),
        .dataIn(dataIn),
        .outValid(outValid),
        .outData(outData),
        .outReady(outReady)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are sampled 3ns later.
    task automatic applyStimulus(input logic [15:0] a, input logic [31:0] d, input logic we, input logic rdy);
        dataAddr     = a;
        dataOut      = d;
        dataWrEnable = we;
        outReady     = rdy;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] model[$];
        logic [7:0] expBytes[8];
        int sent;
        int received;

        vecs[0]  = '{16'h0010, 32'h11111111, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{16'h0010, 32'hDEADBEEF, 1'b1, 1'b1, 32'h11111111};
        vecs[2]  = '{16'h0010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        vecs[3]  = '{16'h1234, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[4]  = '{16'h1234, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0};
        vecs[5]  = '{16'h1234, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[6]  = '{16'h0000, 32'h0BADF00D, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{16'h0100, 32'h12345678, 1'b1, 1'b1, 32'h0};
        vecs[8]  = '{16'h0000, 32'h0,        1'b0, 1'b1, 32'h0BADF00D};
        vecs[9]  = '{16'h00FF, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{16'h00FF, 32'h0,        1'b0, 1'b1, 32'hA5A5A5A5};
        vecs[11] = '{16'hFF00, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[12] = '{16'hFF01, 32'h0,        1'b0, 1'b1, 32'h00000001};
        vecs[13] = '{16'hFF03, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[14] = '{16'h0010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};

        rst = 1'b0;
        applyStimulus(16'hFF01, 32'h0, 1'b0, 1'b0);
        checkOutput("reset outValid", 32'(outValid), 32'h0);
        checkOutput("reset status", dataIn, 32'h00000001);
        applyStimulus(16'hFF02, 32'h0, 1'b0, 1'b0);
        checkOutput("reset cycle", dataIn, 32'h0);
        tick();
        tick();
        applyStimulus(16'hFF02, 32'h0, 1'b0, 1'b0);
        checkOutput("cycle held in reset", dataIn, 32'h0);
        tick();
        rst = 1'b1;
        applyStimulus(16'hFF02, 32'h0, 1'b0, 1'b0);
        checkOutput("cycle after release", dataIn, 32'h0);
        tick();
        applyStimulus(16'hFF02, 32'h0, 1'b0, 1'b0);
        checkOutput("cycle first edge", dataIn, 32'h1);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].we, 1'b0);
            if (vecs[i].chkData) begin
                checkOutput($sformatf("vec%0d dataIn", i), dataIn, vecs[i].expData);
            end
            checkOutput($sformatf("vec%0d outValid", i), 32'(outValid), 32'h0);
            tick();
        end

        // Fill past capacity with the consumer stalled; head must not fall through or move.
        for (int b = 1; b <= 9; b++) begin
            applyStimulus(16'hFF00, 32'(b), 1'b1, 1'b0);
            checkOutput($sformatf("fill%0d outValid", b), 32'(outValid), (b == 1) ? 32'h0 : 32'h1);
            if (b > 1) begin
                checkOutput($sformatf("fill%0d head", b), 32'(outData), 32'h01);
            end
            tick();
        end
        applyStimulus(16'hFF01, 32'h0, 1'b0, 1'b0);
        checkOutput("fill status", dataIn, 32'h00000086);
        checkOutput("fill head hold", 32'(outData), 32'h01);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(16'hFF01, 32'h0, 1'b0, 1'b1);
            checkOutput($sformatf("drain%0d outValid", k), 32'(outValid), 32'h1);
            checkOutput($sformatf("drain%0d byte", k), 32'(outData), 32'(k));
            tick();
        end
        applyStimulus(16'hFF01, 32'h0, 1'b0, 1'b0);
        checkOutput("drained status", dataIn, 32'h00000005);
        checkOutput("drained outValid", 32'(outValid), 32'h0);
        applyStimulus(16'hFF01, 32'h12345678, 1'b1, 1'b0);
        tick();
        applyStimulus(16'hFF01, 32'h0, 1'b0, 1'b0);
        checkOutput("overflow cleared", dataIn, 32'h00000001);

        // Push into a full FIFO while it pops in the same edge.
        for (int b = 0; b < 8; b++) begin
            applyStimulus(16'hFF00, 32'h10 + 32'(b), 1'b1, 1'b0);
            tick();
        end
        applyStimulus(16'hFF00, 32'h55, 1'b1, 1'b1);
        checkOutput("full pushpop head", 32'(outData), 32'h10);
        tick();
        applyStimulus(16'hFF01, 32'h0, 1'b0, 1'b0);
        checkOutput("full pushpop status", dataIn, 32'h00000082);
        expBytes = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
        for (int k = 0; k < 8; k++) begin
            applyStimulus(16'hFF01, 32'h0, 1'b0, 1'b1);
            checkOutput($sformatf("pushpop drain%0d", k), 32'(outData), 32'(expBytes[k]));
            tick();
        end
        applyStimulus(16'hFF01, 32'h0, 1'b0, 1'b0);
        checkOutput("pushpop empty status", dataIn, 32'h00000001);

        // Streaming across pointer wrap with a randomly stalling consumer.
        sent = 0;
        received = 0;
        for (int c = 0; c < 400 && received < 20; c++) begin
            logic rdy;
            logic doPush;
            logic [7:0] val;
            rdy = 1'($urandom_range(0, 1));
            doPush = (sent < 20) && ((model.size() < FIFO_DEPTH) || (rdy && model.size() != 0));
            val = 8'hA0 + 8'(sent);
            applyStimulus(doPush ? 16'hFF00 : 16'hFF01, 32'(val), doPush, rdy);
            checkOutput("stream outValid", 32'(outValid), (model.size() != 0) ? 32'h1 : 32'h0);
            if (model.size() != 0) begin
                checkOutput("stream byte", 32'(outData), 32'(model[0]));
            end
            tick();
            if (model.size() != 0 && rdy) begin
                void'(model.pop_front());
                received++;
            end
            if (doPush) begin
                model.push_back(val);
                sent++;
            end
        end
        checkOutput("stream received", 32'(received), 32'd20);
        applyStimulus(16'hFF01, 32'h0, 1'b0, 1'b0);
        checkOutput("stream status", dataIn, 32'h00000001);

        applyStimulus(16'hFF02, 32'hFFFFFFFE, 1'b1, 1'b0);
        tick();
        applyStimulus(16'hFF02, 32'h0, 1'b0, 1'b0);
        checkOutput("cycle load", dataIn, 32'hFFFFFFFE);
        tick();
        applyStimulus(16'hFF02, 32'h0, 1'b0, 1'b0);
        checkOutput("cycle max", dataIn, 32'hFFFFFFFF);
        tick();
        applyStimulus(16'hFF02, 32'h0, 1'b0, 1'b0);
        checkOutput("cycle wrap", dataIn, 32'h0);

        // Asynchronous reset between edges with bytes queued.
        tick();
        for (int b = 0; b < 3; b++) begin
            applyStimulus(16'hFF00, 32'h31 + 32'(b), 1'b1, 1'b0);
            tick();
        end
        applyStimulus(16'hFF01, 32'h0, 1'b0, 1'b0);
        checkOutput("queued status", dataIn, 32'h00000030);
        checkOutput("queued outValid", 32'(outValid), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async reset outValid", 32'(outValid), 32'h0);
        tick();
        rst = 1'b1;
        applyStimulus(16'hFF01, 32'h0, 1'b0, 1'b0);
        checkOutput("post reset status", dataIn, 32'h00000001);
        applyStimulus(16'hFF02, 32'h0, 1'b0, 1'b0);
        checkOutput("post reset cycle", dataIn, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 Parameter RAM_WORDS, 256, number of 32-bit RAM words, power of two, at most 65280.
REQ-002 Parameter FIFO_DEPTH, 8, number of output FIFO entries, power of two, 2..16.
REQ-003 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous, active-low.
REQ-005 Port dataAddr, input, 16, word address from the CPU data port.
REQ-006 Port dataOut, input, 32, write data from the CPU.
REQ-007 Port dataWrEnable, input, 1, write strobe from the CPU; a write is performed on each clk edge where it is high.
REQ-008 Port dataIn, output, 32, read data returned to the CPU.
REQ-009 Port outValid, output, 1, output stream byte valid.
REQ-010 Port outData, output, 8, output stream byte.
REQ-011 Port outReady, input, 1, downstream consumer ready.

Function
REQ-012 The address map SHALL be:
- 0x0000..RAM_WORDS-1: RAM.
- 0xFF00: OUT_DATA.
- 0xFF01: STATUS.
- 0xFF02: CYCLE.
- All other addresses: unmapped.
REQ-013 Reads SHALL be combinational: dataIn reflects dataAddr in the same cycle, with zero wait states and no read strobe.
REQ-014 A RAM write SHALL store dataOut at the clk edge; a same-cycle read of that address SHALL return the old value, and the new value SHALL be visible from the next cycle.
REQ-015 An unmapped read SHALL return 0; an unmapped write SHALL have no effect.
REQ-016 An OUT_DATA read SHALL return 0.
REQ-017 An OUT_DATA write SHALL push dataOut[7:0] into the FIFO when the FIFO is not full, or when a pop occurs in the same cycle.
REQ-018 An OUT_DATA write to a full FIFO with no same-cycle pop SHALL be dropped and SHALL set the sticky overflow flag.
REQ-019 A STATUS read SHALL return the following fields, with all other bits 0:
- bit0: empty.
- bit1: full.
- bit2: overflow.
- bits[8:4]: count, from 0 to FIFO_DEPTH.
REQ-020 A STATUS write of any value SHALL clear overflow.
REQ-021 If a STATUS write and an overflowing OUT_DATA write occur in the same cycle, overflow SHALL be set. (This cannot happen on a single port; the case is listed for completeness.)
REQ-022 CYCLE SHALL be a 32-bit counter that increments every clk cycle and wraps from 0xFFFFFFFF to 0x00000000.
REQ-023 A CYCLE write SHALL load dataOut exactly; the load has priority over the increment, so the counter reads dataOut on the next cycle and dataOut+1 the cycle after.
REQ-024 outValid SHALL equal (count != 0), and outData SHALL be the head entry.
REQ-025 A pop SHALL occur on a clk edge where outValid and outReady are both high; the head pointer then advances modulo FIFO_DEPTH.
REQ-026 The FIFO SHALL NOT fall through: a byte pushed into an empty FIFO is presented on outValid no earlier than the next cycle.
REQ-027 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-028 Read and write pointers SHALL wrap modulo FIFO_DEPTH, and full/empty SHALL be derived from count.
REQ-029 outData SHALL remain stable while outValid is high and outReady is low.
REQ-030 An X on outReady while outValid is low SHALL NOT affect state.

Reset
REQ-031 While rst is low, the following SHALL hold immediately, without waiting for clk:
- count, pointers, overflow = 0.
- CYCLE = 0.
- outValid = 0.
REQ-032 RAM and FIFO storage contents SHALL NOT be reset; outData is don't-care while outValid is 0.
REQ-033 If rst is asserted mid-operation, queued bytes SHALL be discarded and no pop or push SHALL be recorded for that cycle.
REQ-034 After rst is released, the first clk edge SHALL increment CYCLE to 1 and SHALL perform any write presented at that edge.

Verification
REQ-035 RAM write/read: write 0xDEADBEEF to 0x0010, read 0x0010 in the same cycle (returns the old value), then on the next cycle -> 0xDEADBEEF; read 0x1234 (unmapped) -> 0.
REQ-036 FIFO fill/overflow: with outReady=0, write bytes 0x01..0x09 to 0xFF00 -> STATUS = 0x086 (count 8, full, overflow); drain -> bytes 0x01..0x08 in order, then STATUS = 0x005; write STATUS -> 0x001.
REQ-037 Simultaneous push and pop when full: with FIFO full and outReady=1, write 0x55 -> no overflow, count stays 8, and 0x55 emerges last.
REQ-038 Wrap-around: push and pop 20 bytes with outReady toggling pseudo-randomly -> order preserved, and no dropped or duplicated bytes.
REQ-039 CYCLE: write 0xFFFFFFFE -> reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on the following three cycles.
REQ-040 Async reset: assert rst low between clk edges with 3 bytes queued -> outValid drops to 0 immediately, and STATUS = 0x001 and CYCLE = 0 after release.
